// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Hazard, forwarding and flush controller for the RISC-V pipeline.
//   A scoreboard shift register (e[0]=EX .. e[DEPTH-1]=WB) tracks in-flight
//   destination registers. From it the block derives load-use stalls,
//   registered forward selects, redirect flushes, a memory-wait freeze, and
//   saturating stall/flush performance counters.
// Ports:
//   clk, reset (async, active-low)
//   id_*            : ID-stage instruction description
//   redirect        : branch in e[BR_STAGE] is taken
//   mem_stall       : data memory busy, freeze everything
//   pc_write, if_id_write, id_ex_bubble, flush_if_id : combinational controls
//   fwd_sel_a/b     : registered forward selects (0 = regfile, j = entry j)
//   stall_cnt, flush_cnt : saturating counters
module pipeline_hazard_ctrl #(
   parameter int unsigned DEPTH      = 3,
   parameter int unsigned REG_W      = 5,
   parameter int unsigned LOAD_AVAIL = 2,
   parameter int unsigned BR_STAGE   = 1,
   parameter int unsigned CNT_W      = 16
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           id_valid,
   input  logic [REG_W-1:0]               id_rs1,
   input  logic [REG_W-1:0]               id_rs2,
   input  logic                           id_use_rs1,
   input  logic                           id_use_rs2,
   input  logic [REG_W-1:0]               id_rd,
   input  logic                           id_regwrite,
   input  logic                           id_is_load,
   input  logic                           redirect,
   input  logic                           mem_stall,
   output logic                           pc_write,
   output logic                           if_id_write,
   output logic                           id_ex_bubble,
   output logic                           flush_if_id,
   output logic [$clog2(DEPTH+1)-1:0]     fwd_sel_a,
   output logic [$clog2(DEPTH+1)-1:0]     fwd_sel_b,
   output logic [CNT_W-1:0]               stall_cnt,
   output logic [CNT_W-1:0]               flush_cnt
);

   localparam int unsigned SEL_W = $clog2(DEPTH + 1);

   typedef struct packed {
      logic             valid;
      logic [REG_W-1:0] rd;
      logic             regwrite;
      logic             is_load;
   } entry_t;

   entry_t             entry_q [DEPTH];
   entry_t             entry_d [DEPTH];
   logic [SEL_W-1:0]   fwd_a_q, fwd_a_d;
   logic [SEL_W-1:0]   fwd_b_q, fwd_b_d;
   logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;

   logic [REG_W-1:0]   src   [2];
   logic               use_s [2];
   logic               hit   [2];
   logic               hz    [2];
   logic [SEL_W-1:0]   sel   [2];
   logic               hazard;
   logic               issue;

   // Scoreboard lookup: the youngest matching producer wins, so the search
   // stops at the first hit while walking from e[0] towards WB.
   always_comb begin
      src[0]   = id_rs1;
      src[1]   = id_rs2;
      use_s[0] = id_use_rs1;
      use_s[1] = id_use_rs2;
      for (int unsigned s = 0; s < 2; s++) begin
         hit[s] = 1'b0;
         hz[s]  = 1'b0;
         sel[s] = '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            if (!hit[s] && use_s[s] && entry_q[i].valid && entry_q[i].regwrite &&
                (entry_q[i].rd != '0) && (entry_q[i].rd == src[s])) begin
               hit[s] = 1'b1;
               // Non-load results are always forwardable (threshold 1).
               if (entry_q[i].is_load && (i + 1 < LOAD_AVAIL))
                  hz[s] = 1'b1;
               // The WB entry is served by the write-first register file.
               if (i + 1 <= DEPTH - 1)
                  sel[s] = SEL_W'(i + 1);
            end
         end
      end
      hazard = id_valid && (hz[0] || hz[1]);
      issue  = id_valid && !hazard && !mem_stall && !redirect;
   end

   // Pipeline control outputs, priority reset > mem_stall > redirect > hazard.
   always_comb begin
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      id_ex_bubble = 1'b0;
      flush_if_id  = 1'b0;
      if (!reset) begin
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
         id_ex_bubble = 1'b1;
      end else if (mem_stall) begin
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
      end else if (redirect) begin
         id_ex_bubble = 1'b1;
         flush_if_id  = 1'b1;
      end else if (hazard) begin
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
         id_ex_bubble = 1'b1;
      end
   end

   // Next state; a memory freeze simply leaves every register at its _q value.
   always_comb begin
      entry_d     = entry_q;
      fwd_a_d     = fwd_a_q;
      fwd_b_d     = fwd_b_q;
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (!mem_stall) begin
         for (int unsigned i = 1; i < DEPTH; i++)
            entry_d[i] = entry_q[i-1];
         entry_d[0] = issue ? {1'b1, id_rd, id_regwrite, id_is_load} : '0;
         fwd_a_d    = issue ? sel[0] : '0;
         fwd_b_d    = issue ? sel[1] : '0;
         if (redirect) begin
            for (int unsigned i = 0; i <= BR_STAGE; i++)
               entry_d[i] = '0;
            if (flush_cnt_q != '1)
               flush_cnt_d = flush_cnt_q + 1'b1;
         end else if (hazard) begin
            if (stall_cnt_q != '1)
               stall_cnt_d = stall_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < DEPTH; i++)
            entry_q[i] <= '0;
         fwd_a_q     <= '0;
         fwd_b_q     <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         for (int unsigned i = 0; i < DEPTH; i++)
            entry_q[i] <= entry_d[i];
         fwd_a_q     <= fwd_a_d;
         fwd_b_q     <= fwd_b_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign fwd_sel_a = fwd_a_q;
   assign fwd_sel_b = fwd_b_q;
   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: a default instance (u_d) and a
// deep instance (u_x: DEPTH=5, LOAD_AVAIL=3, BR_STAGE=2) share all inputs.
module tb_pipeline_hazard_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       id_valid, id_use_rs1, id_use_rs2, id_regwrite, id_is_load;
   logic [4:0] id_rs1, id_rs2, id_rd;
   logic       redirect, mem_stall;

   logic       pc_write, if_id_write, id_ex_bubble, flush_if_id;
   logic [1:0] fwd_sel_a, fwd_sel_b;
   logic [15:0] stall_cnt, flush_cnt;

   logic       x_pc_write, x_if_id_write, x_id_ex_bubble, x_flush_if_id;
   logic [2:0] x_fwd_sel_a, x_fwd_sel_b;
   logic [15:0] x_stall_cnt, x_flush_cnt;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   pipeline_hazard_ctrl u_d (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
      .id_regwrite(id_regwrite), .id_is_load(id_is_load), .redirect(redirect),
      .mem_stall(mem_stall), .pc_write(pc_write), .if_id_write(if_id_write),
      .id_ex_bubble(id_ex_bubble), .flush_if_id(flush_if_id), .fwd_sel_a(fwd_sel_a),
      .fwd_sel_b(fwd_sel_b), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   pipeline_hazard_ctrl #(.DEPTH(5), .REG_W(5), .LOAD_AVAIL(3), .BR_STAGE(2), .CNT_W(16)) u_x (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
      .id_regwrite(id_regwrite), .id_is_load(id_is_load), .redirect(redirect),
      .mem_stall(mem_stall), .pc_write(x_pc_write), .if_id_write(x_if_id_write),
      .id_ex_bubble(x_id_ex_bubble), .flush_if_id(x_flush_if_id), .fwd_sel_a(x_fwd_sel_a),
      .fwd_sel_b(x_fwd_sel_b), .stall_cnt(x_stall_cnt), .flush_cnt(x_flush_cnt)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present an instruction in ID: valid, rs1, use1, rs2, use2, rd, regwrite, load.
   task automatic drv(input logic v, input logic [4:0] r1, input logic u1,
                      input logic [4:0] r2, input logic u2, input logic [4:0] rd,
                      input logic rw, input logic ld);
      id_valid = v;  id_rs1 = r1; id_use_rs1 = u1; id_rs2 = r2; id_use_rs2 = u2;
      id_rd = rd; id_regwrite = rw; id_is_load = ld;
   endtask

   task automatic idle();
      drv(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      redirect = 1'b0;
      mem_stall = 1'b0;
   endtask

   task automatic do_reset();
      idle();
      reset = 1'b0;
      tick();
      reset = 1'b1;
   endtask

   task automatic test_reset();
      idle();
      reset = 1'b0;
      #1;
      n_vec++; if (pc_write !== 1'b0) begin n_err++; $display("FAIL rst_pc_write: got %0b expected 0", pc_write); end
      n_vec++; if (if_id_write !== 1'b0) begin n_err++; $display("FAIL rst_if_id_write: got %0b expected 0", if_id_write); end
      n_vec++; if (id_ex_bubble !== 1'b1) begin n_err++; $display("FAIL rst_bubble: got %0b expected 1", id_ex_bubble); end
      n_vec++; if (flush_if_id !== 1'b0) begin n_err++; $display("FAIL rst_flush: got %0b expected 0", flush_if_id); end
      n_vec++; if (fwd_sel_a !== 2'd0 || fwd_sel_b !== 2'd0) begin n_err++; $display("FAIL rst_fwd: got %0d/%0d expected 0/0", fwd_sel_a, fwd_sel_b); end
      n_vec++; if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin n_err++; $display("FAIL rst_cnt: got %0d/%0d expected 0/0", stall_cnt, flush_cnt); end
      tick();
      reset = 1'b1;
   endtask

   task automatic test_load_use();
      do_reset();
      drv(1, 5'd1, 1, 5'd0, 0, 5'd5, 1, 1);           // ld x5,0(x1)
      #1;
      n_vec++; if (id_ex_bubble !== 1'b0 || pc_write !== 1'b1) begin n_err++; $display("FAIL lu_first_issue: got bubble=%0b pc=%0b expected 0/1", id_ex_bubble, pc_write); end
      tick();
      drv(1, 5'd5, 1, 5'd7, 1, 5'd6, 1, 0);           // add x6,x5,x7
      #1;
      n_vec++; if (id_ex_bubble !== 1'b1 || pc_write !== 1'b0 || if_id_write !== 1'b0) begin n_err++; $display("FAIL lu_stall: got bubble=%0b pc=%0b ifid=%0b expected 1/0/0", id_ex_bubble, pc_write, if_id_write); end
      tick();
      n_vec++; if (stall_cnt !== 16'd1) begin n_err++; $display("FAIL lu_stall_cnt: got %0d expected 1", stall_cnt); end
      n_vec++; if (id_ex_bubble !== 1'b0 || pc_write !== 1'b1) begin n_err++; $display("FAIL lu_release: got bubble=%0b pc=%0b expected 0/1", id_ex_bubble, pc_write); end
      tick();
      idle();
      n_vec++; if (fwd_sel_a !== 2'd2 || fwd_sel_b !== 2'd0) begin n_err++; $display("FAIL lu_fwd: got %0d/%0d expected 2/0", fwd_sel_a, fwd_sel_b); end
   endtask

   task automatic test_forward();
      do_reset();
      drv(1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0); tick();   // add x5
      drv(1, 5'd5, 1, 5'd5, 1, 5'd8, 1, 0);           // sub x8,x5,x5
      #1;
      n_vec++; if (id_ex_bubble !== 1'b0) begin n_err++; $display("FAIL fw_no_stall: got %0b expected 0", id_ex_bubble); end
      tick();
      n_vec++; if (fwd_sel_a !== 2'd1 || fwd_sel_b !== 2'd1) begin n_err++; $display("FAIL fw_dist1: got %0d/%0d expected 1/1", fwd_sel_a, fwd_sel_b); end
      drv(1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0); tick();   // add x5
      drv(1, 5'd1, 1, 5'd2, 1, 5'd9, 1, 0); tick();   // independent
      drv(1, 5'd5, 1, 5'd5, 1, 5'd8, 1, 0); tick();
      n_vec++; if (fwd_sel_a !== 2'd2 || fwd_sel_b !== 2'd2) begin n_err++; $display("FAIL fw_dist2: got %0d/%0d expected 2/2", fwd_sel_a, fwd_sel_b); end
      drv(1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0); tick();
      drv(1, 5'd1, 1, 5'd2, 1, 5'd9, 1, 0); tick();
      drv(1, 5'd1, 1, 5'd2, 1, 5'd10, 1, 0); tick();
      drv(1, 5'd5, 1, 5'd5, 1, 5'd8, 1, 0); tick();
      idle();
      n_vec++; if (fwd_sel_a !== 2'd0 || fwd_sel_b !== 2'd0) begin n_err++; $display("FAIL fw_dist3: got %0d/%0d expected 0/0", fwd_sel_a, fwd_sel_b); end
      n_vec++; if (stall_cnt !== 16'd0) begin n_err++; $display("FAIL fw_stall_cnt: got %0d expected 0", stall_cnt); end
   endtask

   task automatic test_x0_unused();
      do_reset();
      drv(1, 5'd1, 1, 5'd0, 0, 5'd0, 1, 1); tick();   // ld x0
      drv(1, 5'd0, 1, 5'd0, 1, 5'd6, 1, 0);           // reads x0
      #1;
      n_vec++; if (id_ex_bubble !== 1'b0 || pc_write !== 1'b1) begin n_err++; $display("FAIL x0_stall: got bubble=%0b pc=%0b expected 0/1", id_ex_bubble, pc_write); end
      tick();
      n_vec++; if (fwd_sel_a !== 2'd0) begin n_err++; $display("FAIL x0_fwd: got %0d expected 0", fwd_sel_a); end
      drv(1, 5'd1, 1, 5'd0, 0, 5'd5, 1, 1); tick();   // ld x5
      drv(1, 5'd5, 0, 5'd5, 0, 5'd6, 1, 0);           // names x5, reads nothing
      #1;
      n_vec++; if (id_ex_bubble !== 1'b0) begin n_err++; $display("FAIL unused_stall: got %0b expected 0", id_ex_bubble); end
      tick();
      idle();
      n_vec++; if (fwd_sel_a !== 2'd0 || stall_cnt !== 16'd0) begin n_err++; $display("FAIL unused_fwd: got sel=%0d cnt=%0d expected 0/0", fwd_sel_a, stall_cnt); end
   endtask

   task automatic test_redirect();
      do_reset();
      drv(1, 5'd1, 1, 5'd2, 1, 5'd0, 0, 0); tick();   // branch
      drv(1, 5'd1, 1, 5'd2, 1, 5'd10, 1, 0); tick();  // add x10 (wrong path)
      drv(1, 5'd10, 1, 5'd0, 0, 5'd12, 1, 0);
      redirect = 1'b1;
      #1;
      n_vec++; if (flush_if_id !== 1'b1 || pc_write !== 1'b1 || id_ex_bubble !== 1'b1) begin n_err++; $display("FAIL br_ctrl: got flush=%0b pc=%0b bubble=%0b expected 1/1/1", flush_if_id, pc_write, id_ex_bubble); end
      tick();
      redirect = 1'b0;
      n_vec++; if (flush_cnt !== 16'd1) begin n_err++; $display("FAIL br_cnt: got %0d expected 1", flush_cnt); end
      drv(1, 5'd10, 1, 5'd0, 0, 5'd13, 1, 0);         // x10 producer was squashed
      tick();
      n_vec++; if (fwd_sel_a !== 2'd0) begin n_err++; $display("FAIL br_squash: got %0d expected 0", fwd_sel_a); end
      // Redirect coinciding with a load-use hazard.
      do_reset();
      drv(1, 5'd1, 1, 5'd0, 0, 5'd5, 1, 1); tick();
      drv(1, 5'd5, 1, 5'd0, 0, 5'd6, 1, 0);
      redirect = 1'b1;
      #1;
      n_vec++; if (pc_write !== 1'b1 || flush_if_id !== 1'b1) begin n_err++; $display("FAIL br_hz_ctrl: got pc=%0b flush=%0b expected 1/1", pc_write, flush_if_id); end
      tick();
      idle();
      n_vec++; if (stall_cnt !== 16'd0 || flush_cnt !== 16'd1) begin n_err++; $display("FAIL br_hz_cnt: got stall=%0d flush=%0d expected 0/1", stall_cnt, flush_cnt); end
   endtask

   task automatic test_mem_stall();
      do_reset();
      drv(1, 5'd1, 1, 5'd0, 0, 5'd4, 1, 0); tick();   // add x4
      drv(1, 5'd4, 1, 5'd0, 0, 5'd5, 1, 1); tick();   // ld x5,0(x4)
      n_vec++; if (fwd_sel_a !== 2'd1) begin n_err++; $display("FAIL ms_pre_fwd: got %0d expected 1", fwd_sel_a); end
      drv(1, 5'd5, 1, 5'd7, 1, 5'd6, 1, 0);           // add x6,x5,x7
      mem_stall = 1'b1;
      redirect = 1'b1;
      #1;
      n_vec++; if (pc_write !== 1'b0 || if_id_write !== 1'b0 || id_ex_bubble !== 1'b0 || flush_if_id !== 1'b0) begin n_err++; $display("FAIL ms_ctrl: got pc=%0b ifid=%0b bubble=%0b flush=%0b expected 0/0/0/0", pc_write, if_id_write, id_ex_bubble, flush_if_id); end
      tick();
      redirect = 1'b0;
      tick();
      tick();
      n_vec++; if (fwd_sel_a !== 2'd1 || stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin n_err++; $display("FAIL ms_hold: got sel=%0d stall=%0d flush=%0d expected 1/0/0", fwd_sel_a, stall_cnt, flush_cnt); end
      mem_stall = 1'b0;
      #1;
      n_vec++; if (id_ex_bubble !== 1'b1 || pc_write !== 1'b0) begin n_err++; $display("FAIL ms_bubble: got bubble=%0b pc=%0b expected 1/0", id_ex_bubble, pc_write); end
      tick();
      n_vec++; if (id_ex_bubble !== 1'b0 || stall_cnt !== 16'd1) begin n_err++; $display("FAIL ms_one_bubble: got bubble=%0b cnt=%0d expected 0/1", id_ex_bubble, stall_cnt); end
      tick();
      idle();
      n_vec++; if (fwd_sel_a !== 2'd2) begin n_err++; $display("FAIL ms_fwd: got %0d expected 2", fwd_sel_a); end
   endtask

   task automatic test_deep();
      do_reset();
      drv(1, 5'd1, 1, 5'd0, 0, 5'd5, 1, 1); tick();   // ld x5
      drv(1, 5'd5, 1, 5'd7, 1, 5'd6, 1, 0);
      #1;
      n_vec++; if (x_id_ex_bubble !== 1'b1) begin n_err++; $display("FAIL deep_bubble1: got %0b expected 1", x_id_ex_bubble); end
      tick();
      n_vec++; if (x_id_ex_bubble !== 1'b1 || x_pc_write !== 1'b0) begin n_err++; $display("FAIL deep_bubble2: got bubble=%0b pc=%0b expected 1/0", x_id_ex_bubble, x_pc_write); end
      tick();
      n_vec++; if (x_id_ex_bubble !== 1'b0) begin n_err++; $display("FAIL deep_release: got %0b expected 0", x_id_ex_bubble); end
      tick();
      n_vec++; if (x_fwd_sel_a !== 3'd3 || x_stall_cnt !== 16'd2) begin n_err++; $display("FAIL deep_fwd: got sel=%0d cnt=%0d expected 3/2", x_fwd_sel_a, x_stall_cnt); end
      do_reset();
      drv(1, 5'd1, 1, 5'd2, 1, 5'd20, 1, 0); tick();
      drv(1, 5'd1, 1, 5'd2, 1, 5'd21, 1, 0); tick();
      drv(1, 5'd1, 1, 5'd2, 1, 5'd22, 1, 0); tick();
      drv(1, 5'd1, 1, 5'd2, 1, 5'd23, 1, 0); tick();
      idle();
      redirect = 1'b1;
      tick();
      redirect = 1'b0;
      drv(1, 5'd21, 1, 5'd22, 1, 5'd24, 1, 0);        // x21 survives in e[3], x22 squashed
      tick();
      idle();
      n_vec++; if (x_fwd_sel_a !== 3'd4 || x_fwd_sel_b !== 3'd0) begin n_err++; $display("FAIL deep_redirect: got %0d/%0d expected 4/0", x_fwd_sel_a, x_fwd_sel_b); end
      n_vec++; if (x_flush_cnt !== 16'd1) begin n_err++; $display("FAIL deep_flush_cnt: got %0d expected 1", x_flush_cnt); end
   endtask

   task automatic test_reset_midstream();
      do_reset();
      drv(1, 5'd1, 1, 5'd0, 0, 5'd7, 1, 1); tick();   // ld x7
      drv(1, 5'd7, 1, 5'd0, 0, 5'd8, 1, 0); tick();   // stalls once
      tick();                                         // issues
      n_vec++; if (fwd_sel_a !== 2'd2 || stall_cnt !== 16'd1) begin n_err++; $display("FAIL mid_pre: got sel=%0d cnt=%0d expected 2/1", fwd_sel_a, stall_cnt); end
      drv(1, 5'd8, 1, 5'd0, 0, 5'd9, 1, 0);
      #1;
      reset = 1'b0;
      #1;
      n_vec++; if (fwd_sel_a !== 2'd0 || stall_cnt !== 16'd0 || id_ex_bubble !== 1'b1 || pc_write !== 1'b0) begin n_err++; $display("FAIL mid_reset: got sel=%0d cnt=%0d bubble=%0b pc=%0b expected 0/0/1/0", fwd_sel_a, stall_cnt, id_ex_bubble, pc_write); end
      tick();
      reset = 1'b1;
      #1;
      n_vec++; if (id_ex_bubble !== 1'b0 || pc_write !== 1'b1) begin n_err++; $display("FAIL mid_release: got bubble=%0b pc=%0b expected 0/1", id_ex_bubble, pc_write); end
      tick();
      n_vec++; if (fwd_sel_a !== 2'd0) begin n_err++; $display("FAIL mid_first_fwd: got %0d expected 0", fwd_sel_a); end
      drv(1, 5'd9, 1, 5'd0, 0, 5'd10, 1, 0);
      tick();
      idle();
      n_vec++; if (fwd_sel_a !== 2'd1) begin n_err++; $display("FAIL mid_issued: got %0d expected 1", fwd_sel_a); end
   endtask

   initial begin
      idle();
      reset = 1'b0;
      test_reset();
      test_load_use();
      test_forward();
      test_x0_unused();
      test_redirect();
      test_mem_stall();
      test_deep();
      test_reset_midstream();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
